// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial adder sequencer.
//   state_t       : sequencer states with fixed encodings (IDLE/RUN/DONE)
//   DEFAULT_WIDTH : operand/result width used when the top is not overridden
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// -----------------------------------------------------------------------------
// FullAdder
// One-bit full adder used as the single arithmetic cell of the serial adder.
// Ports:
//   a, b  : addend bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
// -----------------------------------------------------------------------------
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: one FullAdder is reused for WIDTH cycles, LSB first, with
// a registered carry. Operands arrive over a valid/ready handshake and the
// result leaves over another valid/ready handshake.
//
// Optional feature (macro SERIAL_ADD_SUB_EN): adds a 'sub' input sampled at
// accept; when set the block computes a - b (mod 2^WIDTH) and cout=1 means
// no borrow.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid, in_ready  : operand handshake
//   a, b, cin           : operands and initial carry
//   sub                 : subtract select (only with SERIAL_ADD_SUB_EN)
//   out_valid, out_ready: result handshake
//   sum, cout           : result and final carry (cout reads 0 unless valid)
//   busy                : high while bits are being processed
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   result;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    // Subtraction is a + ~b + 1, so only the B operand and the seed carry
    // differ from addition; the rest of the datapath is shared.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    FullAdder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Each RUN cycle the new sum bit enters at the MSB while the result
    // shifts right, so after WIDTH cycles bit 0 has reached the LSB.
    // Registers hold in DONE so sum/cout stay stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        carry  <= c_load;
                        cnt    <= '0;
                        result <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    result <= {fa_s, result[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = result;
    assign cout = out_valid & carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl (WIDTH=16). Expected values are
// hand-computed constants. Exercises the SERIAL_ADD_SUB_EN subtract path when
// that macro is defined.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks;
    int failures;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge; all driving and
    // sampling happens at this point, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle in IDLE; returns after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
        a        = av;
        b        = bv;
        cin      = cv;
`ifdef SERIAL_ADD_SUB_EN
        sub      = sv;
`else
        if (sv) $display("[TB] note: subtract request ignored in add-only build");
`endif
        in_valid = 1'b1;
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        checkOutput("in_ready_in_run", 64'(in_ready), 64'd0);
    endtask

    // Wait (bounded) for out_valid and report cycles since the accept cycle.
    task automatic waitResult(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd17);
    endtask

    // Check the result, then hand it off with out_ready=1 and confirm the
    // block is back in IDLE on the following cycle.
    task automatic finishOp(input string tag, input logic [W-1:0] es, input logic ec);
        int lat;
        waitResult(tag, lat);
        checkOutput({tag, "_sum"}, 64'(sum), 64'(es));
        checkOutput({tag, "_cout"}, 64'(cout), 64'(ec));
        checkOutput({tag, "_busy_done"}, 64'(busy), 64'd0);
        out_ready = 1'b1;
        tick();
        checkOutput({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_out_valid_idle"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_cout_idle"}, 64'(cout), 64'd0);
    endtask

    initial begin
        int lat;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub       = 1'b0;
`endif
        out_ready = 1'b1;
        #12;

        // Reset values
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic add, then two carry/wrap cases back-to-back
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        finishOp("basic", 16'h0002, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        finishOp("wrap1", 16'h0000, 1'b1);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        finishOp("wrap2", 16'hFFFF, 1'b1);

        // Back-pressure: result held for 10 cycles, new operands refused
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        waitResult("bp", lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a        = 16'hAAAA;
                b        = 16'h1111;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            checkOutput("bp_sum_hold", 64'(sum), 64'h5555);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("bp_sum_final", 64'(sum), 64'h5555);
        checkOutput("bp_cout", 64'(cout), 64'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_back_idle", 64'(in_ready), 64'd1);
        checkOutput("bp_not_accepted", 64'(busy), 64'd0);

        // Reset mid-run aborts immediately
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        checkOutput("midrst_cout", 64'(cout), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(16'd3, 16'd4, 1'b0, 1'b0);
        finishOp("after_rst", 16'd7, 1'b0);

        // Operand change while running has no effect
        applyStimulus(16'h0010, 16'h0020, 1'b0, 1'b0);
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        cin = 1'b1;
        finishOp("opchg", 16'h0030, 1'b0);
        cin = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
        // Subtraction: cin is ignored, cout=1 means no borrow
        applyStimulus(16'd5, 16'd7, 1'b0, 1'b1);
        finishOp("sub_borrow", 16'hFFFE, 1'b0);
        applyStimulus(16'd7, 16'd5, 1'b1, 1'b1);
        finishOp("sub_noborrow", 16'h0002, 1'b1);
        sub = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
